// File: rtl/mc_datapath_gen_if.sv
// Controller/MIO-facing bundle of the multi-cycle datapath: control strobes
// and memory data in, architectural state and ALU flags out.
interface mc_datapath_gen_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       pc_source;
  logic             iord;
  logic [2:0]       alu_ctrl;
  logic             alusrc_a;
  logic             shamt_sel;
  logic [1:0]       alusrc_b;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             ir_write;
  logic             pc_write;
  logic             pc_write_cond;
  logic             branch_ne;
  logic             trap_en;
  logic [WIDTH-1:0] data_in;
  logic             mio_ready;

  logic [WIDTH-1:0] pc_current;
  logic [WIDTH-1:0] m_addr;
  logic [WIDTH-1:0] data_out;
  logic [31:0]      inst;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] epc;
  logic             trap_taken;

  modport master (
    output pc_source, iord, alu_ctrl, alusrc_a, shamt_sel, alusrc_b, reg_write,
           reg_dst, mem_to_reg, ir_write, pc_write, pc_write_cond, branch_ne,
           trap_en, data_in, mio_ready,
    input  pc_current, m_addr, data_out, inst, zero, overflow, epc, trap_taken
  );

  modport slave (
    input  pc_source, iord, alu_ctrl, alusrc_a, shamt_sel, alusrc_b, reg_write,
           reg_dst, mem_to_reg, ir_write, pc_write, pc_write_cond, branch_ne,
           trap_en, data_in, mio_ready,
    output pc_current, m_addr, data_out, inst, zero, overflow, epc, trap_taken
  );
endinterface

// File: rtl/mc_datapath_gen.sv
// Parametrised multi-cycle MIPS-subset datapath with operand latches,
// memory-ready stall gating and overflow trap capture into EPC.
module mc_datapath_gen #(
  parameter int               WIDTH    = 32,
  parameter int               NREGS    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'('h180)
) (
  input logic              clk,
  input logic              rst,
  mc_datapath_gen_if.slave bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef logic [WIDTH-1:0] word_t;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SRL, ALU_SUB, ALU_SLT
  } alu_op_e;

  word_t       pc_q, pc_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d;
  word_t       alu_out_q, alu_out_d, epc_q, epc_d;
  logic [31:0] ir_q, ir_d;
  logic        trap_taken_q, trap_taken_d;
  word_t       regs_q [NREGS];
  word_t       regs_d [NREGS];

  logic [AW-1:0] rs_idx, rt_idx, wr_idx;
  word_t         rs_val, rt_val, op_a, op_b, imm_sext, alu_res, wr_data, jump_addr;
  logic          ovf, zero, trap, pc_we, rf_we;

  // Upper address bits are ignored when the file has fewer than 32 entries.
  assign rs_idx    = ir_q[21 +: AW];
  assign rt_idx    = ir_q[16 +: AW];
  assign rs_val    = (rs_idx == '0) ? '0 : regs_q[rs_idx];
  assign rt_val    = (rt_idx == '0) ? '0 : regs_q[rt_idx];
  assign imm_sext  = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign jump_addr = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output
    // first, so no path leaves a value held and no latch is inferred.
    op_a = a_q;
    if (bus.alusrc_a) op_a = bus.shamt_sel ? word_t'(ir_q[10:6]) : pc_q;
    unique case (bus.alusrc_b)
      2'd0:    op_b = b_q;
      2'd1:    op_b = word_t'(4);
      2'd2:    op_b = imm_sext;
      default: op_b = imm_sext << 2;
    endcase

    alu_res = '0;
    ovf     = 1'b0;
    case (alu_op_e'(bus.alu_ctrl))
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_ADD: begin
        alu_res = op_a + op_b;
        ovf     = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_NOR: alu_res = ~(op_a | op_b);
      ALU_SRL: alu_res = op_b >> op_a[4:0];
      ALU_SUB: begin
        alu_res = op_a - op_b;
        ovf     = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SLT: alu_res = word_t'($signed(op_a) < $signed(op_b));
    endcase
    zero = (alu_res == '0);
  end

  always_comb begin
    unique case (bus.reg_dst)
      2'd0:    wr_idx = ir_q[16 +: AW];
      2'd1:    wr_idx = ir_q[11 +: AW];
      2'd2:    wr_idx = AW'(31);
      default: wr_idx = '0;
    endcase
    unique case (bus.mem_to_reg)
      2'd0:    wr_data = alu_out_q;
      2'd1:    wr_data = mdr_q;
      2'd2:    wr_data = word_t'({ir_q[15:0], 16'h0000});
      default: wr_data = pc_q;
    endcase
    trap  = bus.mio_ready & bus.trap_en & ovf;
    pc_we = bus.mio_ready & (bus.pc_write | (bus.pc_write_cond & (bus.branch_ne ^ zero)));
    rf_we = bus.mio_ready & bus.reg_write & ~trap & (wr_idx != '0);
  end

  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    mdr_d        = mdr_q;
    a_d          = a_q;
    b_d          = b_q;
    alu_out_d    = alu_out_q;
    epc_d        = epc_q;
    regs_d       = regs_q;
    trap_taken_d = trap;

    if (bus.mio_ready) begin
      mdr_d     = bus.data_in;
      a_d       = rs_val;
      b_d       = rt_val;
      alu_out_d = alu_res;
      if (bus.ir_write) ir_d = bus.data_in[31:0];
    end

    // A trap outranks every other PC source in the same cycle.
    if (trap) begin
      pc_d  = TRAP_VEC;
      epc_d = pc_q - WIDTH'(4);
    end else if (pc_we) begin
      unique case (bus.pc_source)
        2'd0:    pc_d = alu_res;
        2'd1:    pc_d = alu_out_q;
        2'd2:    pc_d = jump_addr;
        default: pc_d = a_q;
      endcase
    end

    if (rf_we) regs_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      mdr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_out_q    <= '0;
      epc_q        <= '0;
      trap_taken_q <= 1'b0;
      // NOTE: the register file must read zero after reset, so it is built
      // from resettable flops rather than an uninitialised memory array.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      mdr_q        <= mdr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      alu_out_q    <= alu_out_d;
      epc_q        <= epc_d;
      trap_taken_q <= trap_taken_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.pc_current = pc_q;
  assign bus.m_addr     = bus.iord ? pc_q : alu_out_q;
  assign bus.data_out   = b_q;
  assign bus.inst       = ir_q;
  assign bus.zero       = zero;
  assign bus.overflow   = ovf;
  assign bus.epc        = epc_q;
  assign bus.trap_taken = trap_taken_q;
endmodule
